// File: rtl/weight_pingpong_bank_if.sv
// Loader/engine bus of the ping-pong weight store.
// master: loader + compute engine side; slave: the weight bank.
// Ports: write stream (wr_*), swap control/status, engine read port (rd_*).
interface weight_pingpong_bank_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 10
);
    logic                        wr_valid;
    logic                        wr_ready;
    logic [DATA_WIDTH-1:0]       wr_data;
    logic                        wr_last;
    logic                        swap;
    logic                        swap_err;
    logic                        shadow_full;
    logic                        active_bank;
    logic [ADDR_WIDTH:0]         wr_words;
    logic                        rd_en;
    logic [ADDR_WIDTH-1:0]       rd_addr;
    logic [LANES*DATA_WIDTH-1:0] rd_data;
    logic                        rd_valid;
    logic                        rd_par_err;

    modport master (
        output wr_valid, wr_data, wr_last, swap, rd_en, rd_addr,
        input  wr_ready, swap_err, shadow_full, active_bank, wr_words,
               rd_data, rd_valid, rd_par_err
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, swap, rd_en, rd_addr,
        output wr_ready, swap_err, shadow_full, active_bank, wr_words,
               rd_data, rd_valid, rd_par_err
    );
endinterface

// File: rtl/weight_pingpong_bank.sv
// Double-buffered weight store: loader packs weights into the shadow bank, engine reads the active bank.
// Latency: read data 1 cycle after rd_en; a packed word is written on the cycle its last lane is accepted.
// Backpressure: wr_ready drops while the shadow bank is FULL, until a swap promotes it.
// Ports: clk, rst_n (async active-low), bus (slave modport: wr_* stream, swap/status, rd_* read port).
// Optional: define WEIGHT_PARITY_EN to store one even-parity bit per weight and flag read mismatches.
module weight_pingpong_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    weight_pingpong_bank_if.slave  bus
);
    localparam int WORD_W = LANES * DATA_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    state_t                state_q, state_d;
    logic [LANE_W-1:0]     lane_ptr_q;
    logic [WORD_W-1:0]     pack_q;
    logic [WORD_W-1:0]     commit_word;
    logic [ADDR_WIDTH:0]   wr_words_q;
    logic                  active_bank_q;
    logic                  swap_err_q;
    logic [WORD_W-1:0]     rd_data_q;
    logic                  rd_valid_q;
    logic                  accept;
    logic                  commit;
    logic                  last_word;
    logic                  do_swap;
    logic [ADDR_WIDTH:0]   waddr;
    logic [ADDR_WIDTH:0]   raddr;

    // Both banks live in one array; the MSB of the index selects the bank.
    logic [WORD_W-1:0]     mem [2*DEPTH];

    assign accept    = bus.wr_valid && (state_q != FULL);
    assign commit    = accept && ((lane_ptr_q == LANE_W'(LANES-1)) || bus.wr_last);
    assign last_word = (wr_words_q == (ADDR_WIDTH+1)'(DEPTH-1));
    assign do_swap   = bus.swap && (state_q == FULL);
    assign waddr     = {~active_bank_q, wr_words_q[ADDR_WIDTH-1:0]};
    assign raddr     = {active_bank_q, bus.rd_addr};

    // The packing register is cleared at every commit, so lanes above the
    // pointer are already zero; only the current lane needs inserting.
    always_comb begin
        commit_word = pack_q;
        commit_word[int'(lane_ptr_q)*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, LOAD: begin
                if (commit && (bus.wr_last || last_word))
                    state_d = FULL;
                else if (accept)
                    state_d = LOAD;
            end
            FULL: begin
                if (bus.swap)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            lane_ptr_q    <= '0;
            pack_q        <= '0;
            wr_words_q    <= '0;
            active_bank_q <= 1'b0;
            swap_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            swap_err_q <= bus.swap && (state_q != FULL);
            if (commit) begin
                lane_ptr_q <= '0;
                pack_q     <= '0;
                wr_words_q <= wr_words_q + 1'b1;
            end else if (accept) begin
                lane_ptr_q <= lane_ptr_q + 1'b1;
                pack_q     <= commit_word;
            end
            if (do_swap) begin
                active_bank_q <= ~active_bank_q;
                wr_words_q    <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit)
            mem[waddr] <= commit_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en)
                rd_data_q <= mem[raddr];
        end
    end

`ifdef WEIGHT_PARITY_EN
    logic [LANES-1:0] par_mem [2*DEPTH];
    logic [LANES-1:0] commit_par;
    logic [LANES-1:0] rd_par_calc;
    logic [WORD_W-1:0] rd_word;
    logic             rd_par_err_q;

    assign rd_word = mem[raddr];

    always_comb begin
        commit_par  = '0;
        rd_par_calc = '0;
        for (int i = 0; i < LANES; i++) begin
            commit_par[i]  = ^commit_word[i*DATA_WIDTH +: DATA_WIDTH];
            rd_par_calc[i] = ^rd_word[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (commit)
            par_mem[waddr] <= commit_par;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_par_err_q <= 1'b0;
        else
            rd_par_err_q <= bus.rd_en && (|(rd_par_calc ^ par_mem[raddr]));
    end

    assign bus.rd_par_err = rd_par_err_q;
`else
    assign bus.rd_par_err = 1'b0;
`endif

    assign bus.wr_ready    = (state_q != FULL);
    assign bus.shadow_full = (state_q == FULL);
    assign bus.active_bank = active_bank_q;
    assign bus.wr_words    = wr_words_q;
    assign bus.swap_err    = swap_err_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
endmodule
